frame_stats: RTL and testbench

Per-frame statistics engine directly downstream of the ping-pong sample buffer. On each buffer-ready pulse it drains exactly DEPTH signed samples through the buffer's read valid/ready handshake. It computes frame energy (sum of squares) and peak magnitude with its index, then presents one result record through a valid/ready handshake to the host/readout logic.

---
 rtl/frame_stats_if.sv | 27 ++
 rtl/frame_stats.sv | 104 ++++++++++
 tb/tb_frame_stats.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_stats_if.sv
// frame_stats_if: sample intake, result record and status signals of frame_stats.
interface frame_stats_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH
);
  logic                  frame_start_i;
  logic [WIDTH-1:0]      sample_i;
  logic                  sample_valid_i;
  logic                  sample_ready_o;
  logic [ACC_WIDTH-1:0]  energy_o;
  logic [WIDTH-1:0]      peak_o;
  logic [ADDR_WIDTH-1:0] peak_index_o;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic                  busy_o;
  logic                  frame_error_o;
  modport slave (
    input  frame_start_i, sample_i, sample_valid_i, result_ready_i,
    output sample_ready_o, energy_o, peak_o, peak_index_o, result_valid_o, busy_o, frame_error_o
  );
  modport master (
    output frame_start_i, sample_i, sample_valid_i, result_ready_i,
    input  sample_ready_o, energy_o, peak_o, peak_index_o, result_valid_o, busy_o, frame_error_o
  );
endinterface

// File: rtl/frame_stats.sv
// frame_stats: drains one DEPTH-sample frame per start pulse and reports energy, peak and peak index.
// Peak/index tracking exists only with FRAME_STATS_PEAK_EN defined; otherwise those outputs read 0.
module frame_stats #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH
) (
  input logic          clk_i,
  input logic          rst_i,
  frame_stats_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] drain_q, drain_d;
  logic pend_q, pend_d, err_q, err_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
  logic [2*WIDTH-1:0] s2_sq_q, s2_sq_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic abort, handshake, restart, take;
  always_comb begin
    abort     = state_q == ACCUM && bus.frame_start_i;
    handshake = state_q == RESULT && bus.result_ready_i;
    restart   = (state_q == IDLE && bus.frame_start_i) || abort ||
                (handshake && (pend_q || bus.frame_start_i));
    take      = state_q == ACCUM && bus.sample_valid_i && !abort;
    state_d   = restart ? ACCUM
              : (take && cnt_q == ADDR_WIDTH'(DEPTH-1)) ? DRAIN
              : (state_q == DRAIN && drain_q == 2'd2) ? RESULT
              : handshake ? IDLE : state_q;
    cnt_d     = restart ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    drain_d   = state_q == DRAIN ? drain_q + 2'd1 : 2'd0;
    pend_d    = restart ? 1'b0 : ((state_q == DRAIN || state_q == RESULT) && bus.frame_start_i) | pend_q;
    err_d     = abort;
    s1_v_d    = take;
    s1_mag_d  = bus.sample_i[WIDTH-1] ? -bus.sample_i : bus.sample_i;
    s2_v_d    = s1_v_q && !restart;
    s2_sq_d   = s1_mag_q * s1_mag_q;
    acc_d     = restart ? '0 : s2_v_q ? acc_q + ACC_WIDTH'(s2_sq_q) : acc_q;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_mag_q <= '0;
      s2_sq_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s1_mag_q <= s1_mag_d;
      s2_sq_q  <= s2_sq_d;
      acc_q    <= acc_d;
    end
  assign bus.sample_ready_o = state_q == ACCUM;
  assign bus.result_valid_o = state_q == RESULT;
  assign bus.busy_o         = state_q != IDLE;
  assign bus.frame_error_o  = err_q;
  assign bus.energy_o       = acc_q;
`ifdef FRAME_STATS_PEAK_EN
  logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d, pidx_q, pidx_d;
  logic [WIDTH-1:0] s2_mag_q, s2_mag_d, peak_q, peak_d;
  logic upd;
  // strict compare keeps the earliest index on ties
  always_comb begin
    s1_idx_d = cnt_q;
    s2_idx_d = s1_idx_q;
    s2_mag_d = s1_mag_q;
    upd      = s2_v_q && s2_mag_q > peak_q;
    peak_d   = restart ? '0 : upd ? s2_mag_q : peak_q;
    pidx_d   = restart ? '0 : upd ? s2_idx_q : pidx_q;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      s1_idx_q <= '0;
      s2_idx_q <= '0;
      s2_mag_q <= '0;
      peak_q   <= '0;
      pidx_q   <= '0;
    end else begin
      s1_idx_q <= s1_idx_d;
      s2_idx_q <= s2_idx_d;
      s2_mag_q <= s2_mag_d;
      peak_q   <= peak_d;
      pidx_q   <= pidx_d;
    end
  assign bus.peak_o       = peak_q;
  assign bus.peak_index_o = pidx_q;
`else
  assign bus.peak_o       = '0;
  assign bus.peak_index_o = '0;
`endif
endmodule

// File: tb/tb_frame_stats.sv
// tb_frame_stats: table vectors, corner sequences and random frames against a sum/max reference model.
module tb_frame_stats;
  localparam int W = 16, D = 4;
`ifdef FRAME_STATS_PEAK_EN
  localparam logic [63:0] PK_MASK = '1;
`else
  localparam logic [63:0] PK_MASK = '0;
`endif
  typedef logic [D-1:0][W-1:0] frame_t;
  typedef struct packed {
    frame_t      s;
    logic [1:0]  gap;
    logic [63:0] e;
    logic [15:0] pk;
    logic [1:0]  ix;
  } vec_t;
  logic clk = 0, rst = 1;
  int n_cmp = 0, n_fail = 0;
  frame_stats_if #(.WIDTH(W), .DEPTH(D)) bus();
  frame_stats #(.WIDTH(W), .DEPTH(D)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] pk(input logic [63:0] v);
    return v & PK_MASK;
  endfunction
  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = 16'(a); f[1] = 16'(b); f[2] = 16'(c); f[3] = 16'(d);
    return f;
  endfunction
  // reference: energy = sum of squares, peak = first maximum of |x|
  function automatic void model(input frame_t f, output longint e, output longint p, output longint ix);
    longint m;
    e = 0; p = 0; ix = 0;
    for (int i = 0; i < D; i++) begin
      m = longint'($signed(f[i]));
      if (m < 0) m = -m;
      e += m * m;
      if (m > p) begin
        p = m;
        ix = longint'(i);
      end
    end
  endfunction
  task automatic chk_idle(input string nm);
    chk({nm, "/ready"}, bus.sample_ready_o, 0);
    chk({nm, "/rvalid"}, bus.result_valid_o, 0);
    chk({nm, "/busy"}, bus.busy_o, 0);
    chk({nm, "/ferr"}, bus.frame_error_o, 0);
    chk({nm, "/energy"}, bus.energy_o, 0);
    chk({nm, "/peak"}, bus.peak_o, 0);
    chk({nm, "/pidx"}, bus.peak_index_o, 0);
  endtask
  // smode: 0 none, 1 start pulse during stall, 2 start together with the handshake
  task automatic run_frame(input string nm, input logic do_start, input frame_t f, input int gap,
                           input int stall, input int smode, input longint e, input longint p,
                           input longint ix);
    int i, cyc;
    logic v, r;
    if (do_start) begin
      bus.frame_start_i = 1;
      step();
      bus.frame_start_i = 0;
      chk({nm, "/ready_on_start"}, bus.sample_ready_o, 1);
    end
    i = 0;
    cyc = 0;
    while (i < D && cyc < 50) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? (cyc % 2 == 0) : 1'($urandom % 2);
      bus.sample_valid_i = v;
      bus.sample_i = f[i];
      r = bus.sample_ready_o;
      step();
      if (v && r) i++;
      cyc++;
    end
    chk({nm, "/accepted"}, i, D);
    bus.sample_valid_i = 1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("%s/ready_drain%0d", nm, k), bus.sample_ready_o, 0);
      chk($sformatf("%s/rvalid_early%0d", nm, k), bus.result_valid_o, 0);
      step();
    end
    bus.sample_valid_i = 0;
    chk({nm, "/latency"}, bus.result_valid_o, 1);
    for (int k = 0; k < 20 && !bus.result_valid_o; k++) step();
    chk({nm, "/energy"}, bus.energy_o, 64'(e));
    chk({nm, "/peak"}, bus.peak_o, pk(64'(p)));
    chk({nm, "/pidx"}, bus.peak_index_o, pk(64'(ix)));
    for (int c = 0; c < stall; c++) begin
      bus.frame_start_i = smode == 1 && c == 2;
      step();
      bus.frame_start_i = 0;
      chk({nm, "/hold_rvalid"}, bus.result_valid_o, 1);
      chk({nm, "/hold_energy"}, bus.energy_o, 64'(e));
      chk({nm, "/hold_peak"}, bus.peak_o, pk(64'(p)));
      chk({nm, "/hold_pidx"}, bus.peak_index_o, pk(64'(ix)));
      chk({nm, "/hold_ferr"}, bus.frame_error_o, 0);
    end
    bus.result_ready_i = 1;
    bus.frame_start_i = smode == 2;
    step();
    bus.result_ready_i = 0;
    bus.frame_start_i = 0;
    chk({nm, "/rvalid_after"}, bus.result_valid_o, 0);
    chk({nm, "/ready_after"}, bus.sample_ready_o, smode != 0);
    chk({nm, "/busy_after"}, bus.busy_o, smode != 0);
    chk({nm, "/ferr_after"}, bus.frame_error_o, 0);
  endtask
  initial begin
    vec_t tbl[7];
    frame_t f;
    longint e, p, ix;
    int gap, stall, sm;
    logic ds;
    bus.frame_start_i = 0;
    bus.sample_i = 0;
    bus.sample_valid_i = 0;
    bus.result_ready_i = 0;
    tbl[0] = '{mk(3, -4, 2, 4), 2'd0, 64'd45, 16'd4, 2'd1};
    tbl[1] = '{mk(-32768, -32768, -32768, -32768), 2'd0, 64'd4294967296, 16'd32768, 2'd0};
    tbl[2] = '{mk(1, 1, 1, 1), 2'd1, 64'd4, 16'd1, 2'd0};
    tbl[3] = '{mk(1, 2, 3, 0), 2'd0, 64'd14, 16'd3, 2'd2};
    tbl[4] = '{mk(0, 0, 0, 0), 2'd1, 64'd0, 16'd0, 2'd0};
    tbl[5] = '{mk(5, -5, 5, -5), 2'd0, 64'd100, 16'd5, 2'd0};
    tbl[6] = '{mk(32767, -32768, -32768, 32767), 2'd0, 64'd4294836226, 16'd32768, 2'd1};
    step();
    step();
    chk_idle("reset");
    rst = 0;
    step();
    chk_idle("post_reset");
    foreach (tbl[t])
      run_frame($sformatf("vec%0d", t), 1'b1, tbl[t].s, int'(tbl[t].gap), 2, 0,
                longint'(tbl[t].e), longint'(tbl[t].pk), longint'(tbl[t].ix));
    // abort after two samples, then a clean frame
    bus.frame_start_i = 1;
    step();
    bus.frame_start_i = 0;
    bus.sample_valid_i = 1;
    bus.sample_i = 7;
    step();
    step();
    bus.sample_valid_i = 0;
    step();
    bus.frame_start_i = 1;
    step();
    bus.frame_start_i = 0;
    chk("abort/ferr", bus.frame_error_o, 1);
    chk("abort/ready", bus.sample_ready_o, 1);
    chk("abort/energy_cleared", bus.energy_o, 0);
    chk("abort/rvalid", bus.result_valid_o, 0);
    step();
    chk("abort/ferr_one_cycle", bus.frame_error_o, 0);
    run_frame("abort_new", 1'b0, mk(1, 2, 3, 0), 0, 0, 0, 14, 3, 2);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort/no_second_result", bus.result_valid_o, 0);
    end
    // stall with a pending start, then simultaneous start + handshake
    f = mk(10, -20, 30, -40);
    model(f, e, p, ix);
    run_frame("stall_pend", 1'b1, f, 0, 10, 1, e, p, ix);
    f = mk(-7, 9, -9, 2);
    model(f, e, p, ix);
    run_frame("pend_frame", 1'b0, f, 2, 1, 2, e, p, ix);
    f = mk(100, 0, -100, 50);
    model(f, e, p, ix);
    run_frame("simul_frame", 1'b0, f, 0, 0, 0, e, p, ix);
    // synchronous reset in the middle of a frame
    bus.frame_start_i = 1;
    step();
    bus.frame_start_i = 0;
    bus.sample_valid_i = 1;
    bus.sample_i = 100;
    step();
    step();
    bus.sample_valid_i = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk_idle("mid_reset");
    bus.sample_valid_i = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_reset/stay_idle_ready", bus.sample_ready_o, 0);
      chk("mid_reset/stay_idle_busy", bus.busy_o, 0);
    end
    bus.sample_valid_i = 0;
    ds = 1;
    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < D; j++)
        case ($urandom % 4)
          0: f[j] = 16'h8000;
          1: f[j] = 16'h7fff;
          default: f[j] = 16'($urandom);
        endcase
      gap = int'($urandom % 3);
      stall = int'($urandom % 5);
      sm = int'($urandom % 3);
      if (sm == 1 && stall < 3) stall = 3;
      model(f, e, p, ix);
      run_frame($sformatf("rand%0d", n), ds, f, gap, stall, sm, e, p, ix);
      ds = sm == 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
